// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - command encodings, FSM states and bus constants for the I2C byte engine
package i2c_pkg;

  localparam logic [2:0] CMD_START  = 3'd0;
  localparam logic [2:0] CMD_WRITE  = 3'd1;
  localparam logic [2:0] CMD_READ   = 3'd2;
  localparam logic [2:0] CMD_STOP   = 3'd3;
  localparam logic [2:0] CMD_RSTART = 3'd4;

  // Open-drain: driving 1 means letting the pull-up win.
  localparam logic RELEASE = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_WR_BITS,
    ST_RD_BITS,
    ST_WR_ACKSLOT,
    ST_RD_ACKSLOT,
    ST_STOP_A,
    ST_STOP_B,
    ST_RS_A,
    ST_RS_B
  } state_t;

  function automatic logic cmd_is_legal(input logic [2:0] cmd);
    return cmd <= CMD_RSTART;
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// rtl/i2c_tick_gen.sv - drive/sample strobes decoded from the shared SCL phase counter
module i2c_tick_gen #(
  parameter int PRESC_W = 8
) (
  input  logic [PRESC_W-1:0] counter,
  input  logic [PRESC_W-1:0] prescaler,
  output logic               low_tick,
  output logic               high_tick
);

  localparam logic [PRESC_W:0] ONE = (PRESC_W+1)'(1);

  // One extra bit so 2P-1 never wraps; a zero prescaler behaves as one.
  logic [PRESC_W:0] p_eff;
  logic [PRESC_W:0] cnt_ext;

  assign p_eff   = (prescaler == '0) ? ONE : {1'b0, prescaler};
  assign cnt_ext = {1'b0, counter};

  assign low_tick  = (cnt_ext == (p_eff - ONE));
  assign high_tick = (cnt_ext == ((p_eff << 1) - ONE));

endmodule

// File: rtl/i2c_byte_engine.sv
// rtl/i2c_byte_engine.sv - one-command-at-a-time I2C data path: START/WRITE/READ/STOP/RSTART
module i2c_byte_engine
  import i2c_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 8
) (
  input  logic               i2c_core_clock_i,
  input  logic               reset_bit_i,
  input  logic [PRESC_W-1:0] counter_detect_edge_i,
  input  logic [PRESC_W-1:0] prescaler_i,
  input  logic               cmd_valid_i,
  input  logic [2:0]         cmd_i,
  input  logic [DATA_W-1:0]  tx_data_i,
  input  logic               ack_bit_i,
  input  logic               sda_i,
  output logic               cmd_ready_o,
  output logic               sda_o,
  output logic [DATA_W-1:0]  rx_data_o,
  output logic               rx_valid_o,
  output logic               ack_received_o,
  output logic               done_o,
  output logic               cmd_err_o,
  output logic               busy_o
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0]  tx_shift, tx_shift_n;
  logic [DATA_W-1:0]  rx_shift, rx_shift_n;
  logic [DATA_W-1:0]  rx_next;
  logic [DATA_W-1:0]  rx_data_n;
  logic               ack_bit_q, ack_bit_n;
  logic               ack_rcv_n;
  logic               sda_n;
  logic               done_n, rx_valid_n, cmd_err_n;
  logic               low_tick, high_tick;

  i2c_tick_gen #(
    .PRESC_W (PRESC_W)
  ) u_tick_gen (
    .counter   (counter_detect_edge_i),
    .prescaler (prescaler_i),
    .low_tick  (low_tick),
    .high_tick (high_tick)
  );

  assign cmd_ready_o = (state == ST_IDLE);
  assign busy_o      = (state != ST_IDLE);
  assign rx_next     = (rx_shift << 1) | DATA_W'(sda_i);

  always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
    if (!reset_bit_i) begin
      state          <= ST_IDLE;
      bit_cnt        <= CNT_FULL;
      tx_shift       <= '0;
      rx_shift       <= '0;
      ack_bit_q      <= 1'b0;
      sda_o          <= RELEASE;
      rx_data_o      <= '0;
      ack_received_o <= 1'b1;
      done_o         <= 1'b0;
      rx_valid_o     <= 1'b0;
      cmd_err_o      <= 1'b0;
    end else begin
      state          <= state_n;
      bit_cnt        <= bit_cnt_n;
      tx_shift       <= tx_shift_n;
      rx_shift       <= rx_shift_n;
      ack_bit_q      <= ack_bit_n;
      sda_o          <= sda_n;
      rx_data_o      <= rx_data_n;
      ack_received_o <= ack_rcv_n;
      done_o         <= done_n;
      rx_valid_o     <= rx_valid_n;
      cmd_err_o      <= cmd_err_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    tx_shift_n = tx_shift;
    rx_shift_n = rx_shift;
    ack_bit_n  = ack_bit_q;
    sda_n      = sda_o;
    rx_data_n  = rx_data_o;
    ack_rcv_n  = ack_received_o;
    done_n     = 1'b0;
    rx_valid_n = 1'b0;
    cmd_err_n  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          if (!cmd_is_legal(cmd_i)) begin
            cmd_err_n = 1'b1;
          end else begin
            tx_shift_n = tx_data_i;
            ack_bit_n  = ack_bit_i;
            bit_cnt_n  = CNT_FULL;
            case (cmd_i)
              CMD_START: state_n = ST_START;
              CMD_WRITE: state_n = ST_WR_BITS;
              CMD_READ:  state_n = ST_RD_BITS;
              CMD_STOP:  state_n = ST_STOP_A;
              default:   state_n = ST_RS_A;
            endcase
          end
        end
      end

      ST_START: begin
        if (high_tick) begin
          sda_n   = 1'b0;
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end

      // MSB always sits at the top of tx_shift; shifting after each sample walks the word.
      ST_WR_BITS: begin
        if (low_tick) begin
          sda_n = tx_shift[DATA_W-1];
        end else if (high_tick) begin
          tx_shift_n = tx_shift << 1;
          bit_cnt_n  = bit_cnt - CNT_ONE;
          if (bit_cnt == CNT_ONE) begin
            bit_cnt_n = CNT_FULL;
            state_n   = ST_RD_ACKSLOT;
          end
        end
      end

      ST_RD_ACKSLOT: begin
        if (low_tick) begin
          sda_n = RELEASE;
        end else if (high_tick) begin
          ack_rcv_n = sda_i;
          done_n    = 1'b1;
          state_n   = ST_IDLE;
        end
      end

      ST_RD_BITS: begin
        if (low_tick) begin
          sda_n = RELEASE;
        end else if (high_tick) begin
          rx_shift_n = rx_next;
          bit_cnt_n  = bit_cnt - CNT_ONE;
          if (bit_cnt == CNT_ONE) begin
            rx_data_n  = rx_next;
            rx_valid_n = 1'b1;
            bit_cnt_n  = CNT_FULL;
            state_n    = ST_WR_ACKSLOT;
          end
        end
      end

      // The ACK/NACK level is left on the line after done.
      ST_WR_ACKSLOT: begin
        if (low_tick) begin
          sda_n = ack_bit_q;
        end else if (high_tick) begin
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end

      ST_STOP_A: begin
        if (low_tick) begin
          sda_n   = 1'b0;
          state_n = ST_STOP_B;
        end
      end

      ST_STOP_B: begin
        if (high_tick) begin
          sda_n   = RELEASE;
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end

      ST_RS_A: begin
        if (low_tick) begin
          sda_n   = RELEASE;
          state_n = ST_RS_B;
        end
      end

      ST_RS_B: begin
        if (high_tick) begin
          sda_n   = 1'b0;
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_byte_engine.sv
// tb/tb_i2c_byte_engine.sv - directed self-checking bench for i2c_byte_engine (8-bit and 16-bit)
module tb_i2c_byte_engine;

  localparam logic [2:0] C_START  = 3'd0;
  localparam logic [2:0] C_WRITE  = 3'd1;
  localparam logic [2:0] C_READ   = 3'd2;
  localparam logic [2:0] C_STOP   = 3'd3;
  localparam logic [2:0] C_RSTART = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  counter;
  logic [7:0]  presc;
  logic [2:0]  cmd;
  logic [15:0] tx;
  logic        ackb, v8, v16, slave_sda;
  logic        sda8, sda16, sda_in8, sda_in16;
  logic        rdy8, rdy16, rxv8, rxv16, ackr8, ackr16;
  logic        done8, done16, err8, err16, busy8, busy16;
  logic [7:0]  rx8;
  logic [15:0] rx16;

  int   n_chk, n_pass;
  int   dn8, dn16, rv8, rv16;
  int   n_hi, cycles;
  logic hi_log [32];
  logic sda_lo;

  always #5 clk = ~clk;

  assign sda_in8  = sda8 & slave_sda;
  assign sda_in16 = sda16 & slave_sda;

  i2c_byte_engine #(.DATA_W(8), .PRESC_W(8)) dut8 (
    .i2c_core_clock_i      (clk),
    .reset_bit_i           (rst_n),
    .counter_detect_edge_i (counter),
    .prescaler_i           (presc),
    .cmd_valid_i           (v8),
    .cmd_i                 (cmd),
    .tx_data_i             (tx[7:0]),
    .ack_bit_i             (ackb),
    .sda_i                 (sda_in8),
    .cmd_ready_o           (rdy8),
    .sda_o                 (sda8),
    .rx_data_o             (rx8),
    .rx_valid_o            (rxv8),
    .ack_received_o        (ackr8),
    .done_o                (done8),
    .cmd_err_o             (err8),
    .busy_o                (busy8)
  );

  i2c_byte_engine #(.DATA_W(16), .PRESC_W(8)) dut16 (
    .i2c_core_clock_i      (clk),
    .reset_bit_i           (rst_n),
    .counter_detect_edge_i (counter),
    .prescaler_i           (presc),
    .cmd_valid_i           (v16),
    .cmd_i                 (cmd),
    .tx_data_i             (tx),
    .ack_bit_i             (ackb),
    .sda_i                 (sda_in16),
    .cmd_ready_o           (rdy16),
    .sda_o                 (sda16),
    .rx_data_o             (rx16),
    .rx_valid_o            (rxv16),
    .ack_received_o        (ackr16),
    .done_o                (done16),
    .cmd_err_o             (err16),
    .busy_o                (busy16)
  );

  function automatic logic [7:0] hi_val();
    return (presc == 8'd0) ? 8'd1 : 8'((presc << 1) - 8'd1);
  endfunction

  function automatic logic [7:0] lo_val();
    return (presc == 8'd0) ? 8'd0 : presc - 8'd1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (counter >= hi_val()) counter = 8'd0;
    else counter = counter + 8'd1;
    if (done8)  dn8++;
    if (done16) dn16++;
    if (rxv8)   rv8++;
    if (rxv16)  rv16++;
  endtask

  task automatic issue(input logic [2:0] c, input logic [15:0] d, input logic ab, input bit w16);
    int guard;
    guard = 0;
    while (counter != hi_val() && guard < 100) begin
      cyc();
      guard++;
    end
    cmd  = c;
    tx   = d;
    ackb = ab;
    v8   = !w16;
    v16  = w16;
    cyc();
    v8  = 1'b0;
    v16 = 1'b0;
  endtask

  // sv holds the slave's SDA level per SCL slot, slot 0 at bit 16.
  task automatic run(input logic [2:0] c, input logic [15:0] d, input logic ab,
                     input logic [16:0] sv, input bit w16, input bit poke);
    int guard;
    bit lo_seen, was_lo;
    n_hi    = 0;
    lo_seen = 0;
    issue(c, d, ab, w16);
    guard = 0;
    while ((w16 ? busy16 : busy8) && guard < 2000) begin
      slave_sda = (n_hi <= 16) ? sv[16-n_hi] : 1'b1;
      if (poke && guard < 10) begin
        cmd = C_WRITE;
        tx  = 16'h0000;
        v8  = !w16;
        v16 = w16;
      end else begin
        v8  = 1'b0;
        v16 = 1'b0;
      end
      if (counter == hi_val() && n_hi < 32) begin
        hi_log[n_hi] = (w16 ? sda16 : sda8) & slave_sda;
        n_hi++;
      end
      was_lo = (counter == lo_val());
      cyc();
      guard++;
      if (was_lo && !lo_seen) begin
        lo_seen = 1;
        sda_lo  = w16 ? sda16 : sda8;
      end
    end
    v8        = 1'b0;
    v16       = 1'b0;
    slave_sda = 1'b1;
    cycles    = guard;
    check("cmd_completes", 32'(guard < 2000), 32'd1);
  endtask

  function automatic logic [15:0] pack_log(input int n);
    logic [15:0] w;
    w = 16'h0;
    for (int i = 0; i < n; i++) w = {w[14:0], hi_log[i]};
    return w;
  endfunction

  initial begin
    n_chk = 0; n_pass = 0;
    dn8 = 0; dn16 = 0; rv8 = 0; rv16 = 0;
    rst_n = 1'b0; counter = 8'd0; presc = 8'd4;
    cmd = 3'd0; tx = 16'h0; ackb = 1'b0; v8 = 1'b0; v16 = 1'b0; slave_sda = 1'b1;
    sda_lo = 1'b0; n_hi = 0; cycles = 0;
    repeat (3) cyc();
    check("rst_sda", 32'(sda8), 32'd1);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_ready", 32'(rdy8), 32'd1);
    check("rst_rx", 32'(rx8), 32'h0);
    check("rst_ackr", 32'(ackr8), 32'd1);
    rst_n = 1'b1;
    repeat (2) cyc();

    // reset in the middle of a WRITE
    issue(C_WRITE, 16'h0000, 1'b0, 0);
    repeat (35) cyc();
    check("mid_busy", 32'(busy8), 32'd1);
    check("mid_sda", 32'(sda8), 32'd0);
    dn8 = 0;
    rst_n = 1'b0;
    #1;
    check("abort_sda", 32'(sda8), 32'd1);
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_ready", 32'(rdy8), 32'd1);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (20) cyc();
    check("abort_no_done", 32'(dn8), 32'd0);
    check("abort_idle", 32'(busy8), 32'd0);

    // START, WRITE 0xA5 with slave ACK, STOP
    dn8 = 0;
    run(C_START, 16'h0, 1'b0, 17'h1FFFF, 0, 0);
    check("start_line_hi", 32'(hi_log[0]), 32'd1);
    check("start_sda", 32'(sda8), 32'd0);
    run(C_WRITE, 16'h00A5, 1'b0, {8'hFF, 1'b0, 8'hFF}, 0, 0);
    check("wr_slots", 32'(n_hi), 32'd9);
    check("wr_bits", 32'(pack_log(8)), 32'h00A5);
    check("wr_ack_line", 32'(hi_log[8]), 32'd0);
    check("wr_ackr", 32'(ackr8), 32'd0);
    run(C_STOP, 16'h0, 1'b0, 17'h1FFFF, 0, 0);
    check("stop_line_lo", 32'(hi_log[0]), 32'd0);
    check("stop_sda", 32'(sda8), 32'd1);
    check("three_dones", 32'(dn8), 32'd3);

    // READ 0x3C, master NACK
    rv8 = 0;
    run(C_READ, 16'h0, 1'b1, {8'h3C, 1'b1, 8'hFF}, 0, 0);
    check("rd_data", 32'(rx8), 32'h3C);
    check("rd_valid_cnt", 32'(rv8), 32'd1);
    check("rd_nack_line", 32'(hi_log[8]), 32'd1);
    check("rd_nack_hold", 32'(sda8), 32'd1);

    // repeated start after WRITE, then after READ-with-ACK (SDA held low)
    run(C_WRITE, 16'h005A, 1'b0, {8'hFF, 1'b0, 8'hFF}, 0, 0);
    check("wr2_bits", 32'(pack_log(8)), 32'h005A);
    run(C_RSTART, 16'h0, 1'b0, 17'h1FFFF, 0, 0);
    check("rs1_low_tick", 32'(sda_lo), 32'd1);
    check("rs1_fall", 32'(sda8), 32'd0);
    check("rs1_idle", 32'(busy8), 32'd0);
    rv8 = 0;
    run(C_READ, 16'h0, 1'b0, {8'h96, 1'b1, 8'hFF}, 0, 0);
    check("rd2_data", 32'(rx8), 32'h96);
    check("rd2_ack_line", 32'(hi_log[8]), 32'd0);
    check("rd2_ack_hold", 32'(sda8), 32'd0);
    run(C_RSTART, 16'h0, 1'b0, 17'h1FFFF, 0, 0);
    check("rs2_rise", 32'(sda_lo), 32'd1);
    check("rs2_line_hi", 32'(hi_log[0]), 32'd1);
    check("rs2_fall", 32'(sda8), 32'd0);
    check("rs2_idle", 32'(busy8), 32'd0);

    // 16-bit word with prescaler 0 (clamped to 1)
    presc = 8'd0;
    dn16 = 0; rv16 = 0;
    run(C_WRITE, 16'h8001, 1'b0, 17'h1FFFE, 1, 0);
    check("w16_slots", 32'(n_hi), 32'd17);
    check("w16_bits", 32'(pack_log(16)), 32'h8001);
    check("w16_ack_line", 32'(hi_log[16]), 32'd0);
    check("w16_ackr", 32'(ackr16), 32'd0);
    check("w16_cycles", 32'(cycles), 32'd34);
    check("w16_done", 32'(dn16), 32'd1);
    check("w16_no_rxv", 32'(rv16), 32'd0);
    check("w16_rx", 32'(rx16), 32'h0);
    check("w16_no_err", 32'(err16), 32'd0);
    check("w16_ready", 32'(rdy16), 32'd1);

    // illegal command, then a WRITE presented while busy
    presc = 8'd4;
    repeat (2) cyc();
    cmd = 3'd6;
    v8  = 1'b1;
    cyc();
    v8 = 1'b0;
    check("err_pulse", 32'(err8), 32'd1);
    check("err_no_busy", 32'(busy8), 32'd0);
    cyc();
    check("err_one_cycle", 32'(err8), 32'd0);
    dn8 = 0;
    run(C_WRITE, 16'h00C3, 1'b0, {8'hFF, 1'b0, 8'hFF}, 0, 1);
    check("busy_wr_bits", 32'(pack_log(8)), 32'h00C3);
    check("busy_wr_done", 32'(dn8), 32'd1);
    repeat (20) cyc();
    check("busy_ignored", 32'(busy8), 32'd0);
    check("busy_no_extra", 32'(dn8), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
